// File: rtl/shift_reg_seq_pkg.sv
// Shared types and register-mode encodings for the shift register command sequencer.
package shift_reg_seq_pkg;

    typedef enum logic [1:0] {
        OP_SHR  = 2'b00,
        OP_SHL  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        LOAD  = 3'd2,
        READ  = 3'd3,
        RESP  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_SHR  = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_PIPO = 2'b11;

endpackage

// File: rtl/shift_reg_sequencer_word_buf.sv
// Tx/rx word buffer pair: tx is tapped one bit at a time, rx is filled bit-wise or in parallel.
module seq_word_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             msb_first,
    input  logic             cap_en,
    input  logic             cap_bit,
    input  logic             par_en,
    input  logic [WIDTH-1:0] par_data,
    output logic             tap_bit,
    output logic [WIDTH-1:0] tx_word,
    output logic [WIDTH-1:0] rx_word
);
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] rx_buf;
    logic [CNT_W-1:0] idx;

    // Transmit and capture share one index so the bit leaving the register lands where the new bit came from.
    assign idx     = msb_first ? (CNT_W'(WIDTH - 1) - cnt) : cnt;
    assign tap_bit = tx_buf[idx];
    assign tx_word = tx_buf;
    assign rx_word = rx_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf <= '0;
            rx_buf <= '0;
        end else begin
            if (load_en) begin
                tx_buf <= load_data;
            end
            if (par_en) begin
                rx_buf <= par_data;
            end else if (cap_en) begin
                rx_buf[idx] <= cap_bit;
            end
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for the Hamming-protected shift register: one command in, displaced word out.
//
// state | meaning
// IDLE  | cmd_ready high, register enable low so self-correction may write back
// SHIFT | WIDTH serial shifts, LSB first (SHR) or MSB first (SHL)
// LOAD  | one-cycle PIPO parallel load, old word captured
// READ  | one-cycle capture of corrected parallel_out, enable held low
// RESP  | rsp_valid high until rsp_ready
module shift_reg_sequencer
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic             last_shift;
    logic             accept;
    logic             tap_bit;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] rx_word;

    assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
    assign last_shift = (cnt == CNT_W'(WIDTH - 1));

    seq_word_buf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_word_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (accept),
        .load_data (cmd_data),
        .cnt       (cnt),
        .msb_first (op_q == OP_SHL),
        .cap_en    (state == SHIFT),
        .cap_bit   (reg_serial_out),
        .par_en    ((state == LOAD) || (state == READ)),
        .par_data  (reg_parallel_out),
        .tap_bit   (tap_bit),
        .tx_word   (tx_word),
        .rx_word   (rx_word)
    );

    // Data drives come from buffer registers gated by state, never from cmd_* directly.
    assign reg_serial_in   = (state == SHIFT) && tap_bit;
    assign reg_parallel_in = (state == LOAD) ? tx_word : '0;
    assign rsp_data        = rx_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= OP_SHR;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            reg_enable <= 1'b0;
            reg_mode   <= MODE_PIPO;
            reg_load   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op_e'(cmd_op);
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_e'(cmd_op))
                            OP_SHR, OP_SHL: begin
                                state      <= SHIFT;
                                reg_enable <= 1'b1;
                                reg_mode   <= cmd_op;
                            end
                            OP_LOAD: begin
                                state      <= LOAD;
                                reg_enable <= 1'b1;
                                reg_mode   <= MODE_PIPO;
                                reg_load   <= 1'b1;
                            end
                            default: begin
                                state <= READ;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    cnt <= last_shift ? '0 : cnt + CNT_W'(1);
                    if (last_shift) begin
                        state      <= RESP;
                        reg_enable <= 1'b0;
                        reg_mode   <= MODE_PIPO;
                        rsp_valid  <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= RESP;
                    reg_enable <= 1'b0;
                    reg_load   <= 1'b0;
                    rsp_valid  <= 1'b1;
                end
                READ: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    cmd_ready  <= 1'b1;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                    reg_enable <= 1'b0;
                    reg_mode   <= MODE_PIPO;
                    reg_load   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer driving a behavioural 32-bit shift register plant.
module tb_shift_reg_sequencer;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             reg_enable;
    logic [1:0]       reg_mode;
    logic             reg_load;
    logic             reg_serial_in;
    logic [WIDTH-1:0] reg_parallel_in;
    logic             reg_serial_out;
    logic [WIDTH-1:0] reg_parallel_out;

    int n_cmp = 0;
    int n_mis = 0;

    // Plant: SHR enters at MSB and exits LSB, SHL enters at LSB and exits MSB; not cleared by sequencer reset.
    logic [WIDTH-1:0] sreg = '0;

    always @(posedge clk) begin
        if (reg_enable) begin
            case (reg_mode)
                2'b00:   sreg <= {reg_serial_in, sreg[WIDTH-1:1]};
                2'b01:   sreg <= {sreg[WIDTH-2:0], reg_serial_in};
                2'b11:   if (reg_load) sreg <= reg_parallel_in;
                default: ;
            endcase
        end
    end

    assign reg_serial_out   = (reg_mode == 2'b01) ? sreg[WIDTH-1] : sreg[0];
    assign reg_parallel_out = sreg;

    shift_reg_sequencer #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .busy             (busy),
        .reg_enable       (reg_enable),
        .reg_mode         (reg_mode),
        .reg_load         (reg_load),
        .reg_serial_in    (reg_serial_in),
        .reg_parallel_in  (reg_parallel_in),
        .reg_serial_out   (reg_serial_out),
        .reg_parallel_out (reg_parallel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_data"}, rsp_data, 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_enable"}, 32'(reg_enable), 32'd0);
        check_eq({tag, "_mode"}, 32'(reg_mode), 32'd3);
        check_eq({tag, "_load"}, 32'(reg_load), 32'd0);
        check_eq({tag, "_sin"}, 32'(reg_serial_in), 32'd0);
        check_eq({tag, "_pin"}, reg_parallel_in, 32'h0);
    endtask

    // Latency counts the accept cycle as cycle 0: LOAD/READ respond in cycle 2, shifts in cycle 33.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] exp_rsp, input int exp_lat, input int hold);
        int   n;
        logic en_seen;
        logic [31:0] held;
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n       = 1;
        en_seen = reg_enable;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!rsp_valid) en_seen |= reg_enable;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_rsp"}, rsp_data, exp_rsp);
        if (op == 2'b11) check_eq({tag, "_no_enable"}, 32'(en_seen), 32'd0);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b10;
            cmd_data  = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, "_hold_data"}, rsp_data, held);
            check_eq({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check_eq({tag, "_hold_enable"}, 32'(reg_enable), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        do_cmd("t1_read", 2'b11, 32'h0, 32'h0000_0000, 2, 0);

        do_cmd("t2_load", 2'b10, 32'hDEAD_BEEF, 32'h0000_0000, 2, 0);
        do_cmd("t2_read", 2'b11, 32'h0, 32'hDEAD_BEEF, 2, 0);

        do_cmd("t3_load", 2'b10, 32'h1234_5678, 32'hDEAD_BEEF, 2, 0);
        do_cmd("t3_shr", 2'b00, 32'hA5A5_A5A5, 32'h1234_5678, 33, 0);
        do_cmd("t3_read", 2'b11, 32'h0, 32'hA5A5_A5A5, 2, 0);

        do_cmd("t4_load", 2'b10, 32'hF000_0000, 32'hA5A5_A5A5, 2, 0);
        do_cmd("t4_shl", 2'b01, 32'h0000_000F, 32'hF000_0000, 33, 0);
        check_eq("t4_plant", sreg, 32'h0000_000F);

        do_cmd("t5_read_hold", 2'b11, 32'h0, 32'h0000_000F, 2, 10);

        // Interrupt an SHR after 16 shifts: plant keeps {BEEF, upper half of CAFEF00D}.
        do_cmd("t6_load", 2'b10, 32'hCAFE_F00D, 32'h0000_000F, 2, 0);
        check_eq("t6_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 32'h0000_BEEF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_eq("t6_mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("t6_async_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_plant", sreg, 32'hBEEF_CAFE);
        do_cmd("t6_shr", 2'b00, 32'h1357_9BDF, 32'hBEEF_CAFE, 33, 0);
        do_cmd("t6_read", 2'b11, 32'h0, 32'h1357_9BDF, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
